mul23_seq_arbiter: RTL and testbench
====================================

Name: mul23_seq_arbiter

Overview:
- Sequences one shared combinational 2x3 array multiplier (2-bit m, 3-bit q, 5-bit p) to compute full 4x6 unsigned products, 10-bit result.
- Uses four partial-product passes with shift-accumulate.
- Two requesters share the unit through a valid/ready handshake and a round-robin or fixed-priority arbiter.
- Sits between the requesting datapaths and a single multiplier instance.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = requester 0 always wins a tie.

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle, one-hot or zero
- req_a0  in  4  requester 0 multiplicand
- req_b0  in  6  requester 0 multiplier
- req_a1  in  4  requester 1 multiplicand
- req_b1  in  6  requester 1 multiplier
- mul_m  out  2  operand to shared multiplier m input
- mul_q  out  3  operand to shared multiplier q input
- mul_p  in  5  product from shared multiplier, combinational in same cycle
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  10  product A*B
- res_id  out  1  requester index that owns res_data
- busy  out  1  high in any state except IDLE

Behaviour:

Reset, asynchronous:
- State = IDLE, step = 0, accumulator = 0, res_valid = 0, res_data = 0, res_id = 0.
- Last-grant pointer = 1, so requester 0 wins the first tie.
- Operand registers = 0.
- Outputs mul_m = 0, mul_q = 0, req_ready = 0, busy = 0.

State machine:
- IDLE:
  - Arbitrate among req_valid bits; req_ready[g] = 1 combinationally for the winner g only.
  - On handshake, latch A and B of g, set res_id = g, clear accumulator and step, update last-grant = g, go to MUL.
  - No valid: stay in IDLE.
- MUL (exactly 4 cycles, step 0..3):
  - Step 0: mul_m = A[1:0], mul_q = B[2:0]. Accumulate mul_p << 0.
  - Step 1: mul_m = A[3:2], mul_q = B[2:0]. Accumulate mul_p << 2.
  - Step 2: mul_m = A[1:0], mul_q = B[5:3]. Accumulate mul_p << 3.
  - Step 3: mul_m = A[3:2], mul_q = B[5:3]. Accumulate mul_p << 5.
  - mul_p is sampled at the end of each step's cycle.
  - After step 3, res_data = final accumulator, res_valid = 1, go to DONE.
- DONE:
  - res_valid, res_data and res_id are held stable until res_ready = 1.
  - On res_ready = 1: res_valid = 0 next cycle, go to IDLE.
  - res_data keeps its last value.

Timing and arithmetic:
- Latency: handshake in cycle T → res_valid high from cycle T+5.
- Minimum issue interval is 6 cycles with res_ready tied high.
- Accumulator is 10 bits, unsigned; the maximum 15*63 = 945 never overflows.
- mul_m and mul_q are 0 outside MUL.

Arbitration:
- Round-robin: on a tie, grant the requester not granted last. A single valid requester is granted regardless of pointer.
- FIXED_PRIO = 1: requester 0 always wins a tie; pointer is unused.
- req_ready is 0 in MUL and DONE. Requests are never accepted while busy.
- Requesters hold valid and operands stable until ready. A deasserted valid before grant is simply not served.

Boundary conditions:
- res_ready high in the same cycle res_valid rises: that cycle completes the transfer and the next cycle returns to IDLE.
- Reset mid-MUL or mid-DONE: the operation is aborted and no result is produced. After reset release, the unit is in IDLE with the reset values above.
- Operand 0 on either side gives result 0 and still takes 4 MUL cycles.

Test Plan:
- Req0 only, A=13, B=45, res_ready=1 → req_ready=01 in cycle T; res_valid at T+5 with res_data=585, res_id=0; mul_m/mul_q sequence (1,5),(3,5),(1,5),(3,5).
- Both valid continuously, A0=15/B0=63, A1=2/B1=3, FIXED_PRIO=0 → grants alternate 0,1,0,1; results 945 (id 0) then 6 (id 1); issue interval 6 cycles.
- Same stimulus with FIXED_PRIO=1 → requester 0 granted every time; req_ready[1] never asserts.
- Req1, A=0, B=63, res_ready held low 3 cycles after res_valid → res_data=0 and id=1 held stable; busy=1; req_ready=00 with req0 valid; accepted on the 4th cycle; IDLE on the next.
- Req0 A=9, B=22; rst_n pulsed low during MUL step 2 → res_valid=0, mul_m=0, busy=0 immediately. After release, req0 A=9, B=22 again → 198 with no stale accumulation.
- Random regression, 1000 transactions with random valid and res_ready → every res_data equals A*B of the granted request; per-requester ordering is preserved; no grant while busy.

Source files
------------

// File: rtl/mul23_seq_arbiter.sv
// Two-requester front end for one shared 2x3 combinational multiplier.
// Each 4x6 product is built from four partial-product passes that are shifted and accumulated.
module mul23_seq_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a0,
    input  logic [5:0] req_b0,
    input  logic [3:0] req_a1,
    input  logic [5:0] req_b1,
    output logic [1:0] mul_m,
    output logic [2:0] mul_q,
    input  logic [4:0] mul_p,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_data,
    output logic       res_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_step;
    logic [9:0] r_acc;
    logic [3:0] r_a;
    logic [5:0] r_b;
    logic       r_last;
    logic       r_res_valid;
    logic [9:0] r_res_data;
    logic       r_res_id;

    logic       w_grant_any;
    logic       w_grant_id;
    logic [2:0] w_shamt;
    logic [9:0] w_pp_shifted;
    logic [9:0] w_acc_sum;

    // On a tie, round-robin favours whoever was not granted last.
    always_comb begin
        w_grant_any = |req_valid;
        w_grant_id  = 1'b0;
        case (req_valid)
            2'b01:   w_grant_id = 1'b0;
            2'b10:   w_grant_id = 1'b1;
            2'b11:   w_grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
            default: w_grant_id = 1'b0;
        endcase
    end

    // Pass order: A lo*B lo, A hi*B lo, A lo*B hi, A hi*B hi.
    always_comb begin
        case (r_step)
            2'd0:    w_shamt = 3'd0;
            2'd1:    w_shamt = 3'd2;
            2'd2:    w_shamt = 3'd3;
            default: w_shamt = 3'd5;
        endcase
        w_pp_shifted = 10'(mul_p) << w_shamt;
        w_acc_sum    = r_acc + w_pp_shifted;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 2'b00;
        mul_m        = 2'd0;
        mul_q        = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    req_ready[w_grant_id] = 1'b1;
                    w_state_next          = S_MUL;
                end
            end
            S_MUL: begin
                mul_m = r_step[0] ? r_a[3:2] : r_a[1:0];
                mul_q = r_step[1] ? r_b[5:3] : r_b[2:0];
                if (r_step == 2'd3) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_acc       <= 10'd0;
            r_a         <= 4'd0;
            r_b         <= 6'd0;
            r_last      <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_data  <= 10'd0;
            r_res_id    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_a      <= w_grant_id ? req_a1 : req_a0;
                        r_b      <= w_grant_id ? req_b1 : req_b0;
                        r_res_id <= w_grant_id;
                        r_last   <= w_grant_id;
                        r_acc    <= 10'd0;
                        r_step   <= 2'd0;
                    end
                end
                S_MUL: begin
                    r_acc  <= w_acc_sum;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_res_data  <= w_acc_sum;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul23_seq_arbiter.sv
// Directed and random checks for mul23_seq_arbiter, with round-robin and fixed-priority instances.
module tb_mul23_seq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_a0;
    logic [5:0] req_b0;
    logic [3:0] req_a1;
    logic [5:0] req_b1;
    logic       res_ready;

    logic [1:0] req_ready;
    logic [1:0] mul_m;
    logic [2:0] mul_q;
    logic [4:0] mul_p;
    logic       res_valid;
    logic [9:0] res_data;
    logic       res_id;
    logic       busy;

    logic [1:0] f_req_ready;
    logic [1:0] f_mul_m;
    logic [2:0] f_mul_q;
    logic [4:0] f_mul_p;
    logic       f_res_valid;
    logic [9:0] f_res_data;
    logic       f_res_id;
    logic       f_busy;

    int checks;
    int errors;

    assign mul_p   = 5'(mul_m) * 5'(mul_q);
    assign f_mul_p = 5'(f_mul_m) * 5'(f_mul_q);

    mul23_seq_arbiter #(.FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .mul_m(mul_m), .mul_q(mul_q), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    mul23_seq_arbiter #(.FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(f_req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .mul_m(f_mul_m), .mul_q(f_mul_q), .mul_p(f_mul_p),
        .res_valid(f_res_valid), .res_ready(res_ready), .res_data(f_res_data),
        .res_id(f_res_id), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gcnt, rcnt, last_g, f_gcnt, f_rcnt, f_r1, nres, exp_v;
        logic [1:0] hs;
        logic       pend [2];
        logic [3:0] ra [2];
        logic [5:0] rb [2];
        int q0[$];
        int q1[$];

        checks = 0;
        errors = 0;
        rst_n = 1'b0; req_valid = 2'b00; res_ready = 1'b0;
        req_a0 = 4'd0; req_b0 = 6'd0; req_a1 = 4'd0; req_b1 = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_m", mul_m, 0);
        chk("rst_mul_q", mul_q, 0);
        chk("rst_req_ready", req_ready, 0);
        $display("reset state checked");

        // Test 1: requester 0 alone, 13*45
        do_reset();
        req_valid = 2'b01; req_a0 = 4'd13; req_b0 = 6'd45; res_ready = 1'b1;
        #1 chk("t1_grant", req_ready, 2'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 2'b00;
            #1;
            chk("t1_mul_m", mul_m, ((k % 2) == 0) ? 1 : 3);
            chk("t1_mul_q", mul_q, 5);
            chk("t1_busy", busy, 1);
        end
        @(negedge clk); #1;
        chk("t1_res_valid", res_valid, 1);
        chk("t1_res_data", res_data, 585);
        chk("t1_res_id", res_id, 0);
        @(negedge clk); #1;
        chk("t1_idle_valid", res_valid, 0);
        chk("t1_idle_busy", busy, 0);
        $display("t1 req0 13*45 -> %0d id %0d", res_data, res_id);

        // Test 2: both valid continuously, round-robin vs fixed priority
        do_reset();
        req_valid = 2'b11; req_a0 = 4'd15; req_b0 = 6'd63; req_a1 = 4'd2; req_b1 = 6'd3;
        res_ready = 1'b1;
        gcnt = 0; rcnt = 0; last_g = 0; f_gcnt = 0; f_rcnt = 0; f_r1 = 0;
        for (int c = 0; c < 26; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("rr_grant", req_ready, ((gcnt % 2) == 0) ? 2'b01 : 2'b10);
                if (gcnt > 0) chk("rr_interval", c - last_g, 6);
                last_g = c;
                gcnt++;
            end
            if (res_valid) begin
                chk("rr_res_data", res_data, ((rcnt % 2) == 0) ? 945 : 6);
                chk("rr_res_id", res_id, rcnt % 2);
                $display("t2 rr result %0d id %0d", res_data, res_id);
                rcnt++;
            end
            if (f_req_ready != 2'b00) begin
                chk("fp_grant", f_req_ready, 2'b01);
                f_gcnt++;
            end
            if (f_req_ready[1]) f_r1++;
            if (f_res_valid) begin
                chk("fp_res_data", f_res_data, 945);
                chk("fp_res_id", f_res_id, 0);
                f_rcnt++;
            end
            @(negedge clk);
        end
        chk("rr_grant_count", gcnt, 5);
        chk("rr_result_count", rcnt, 4);
        chk("fp_grant_count", f_gcnt, 5);
        chk("fp_result_count", f_rcnt, 4);
        chk("fp_ready1_count", f_r1, 0);

        // Test 3: requester 1, zero operand, result back-pressured 3 cycles
        do_reset();
        req_valid = 2'b10; req_a1 = 4'd0; req_b1 = 6'd63; res_ready = 1'b0;
        req_a0 = 4'd5; req_b0 = 6'd7;
        #1 chk("t3_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b01;
        #1 chk("t3_ready_busy", req_ready, 2'b00);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_hold_valid", res_valid, 1);
            chk("t3_hold_data", res_data, 0);
            chk("t3_hold_id", res_id, 1);
            chk("t3_hold_busy", busy, 1);
            chk("t3_hold_ready", req_ready, 2'b00);
            chk("t3_hold_mul_m", mul_m, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1 chk("t3_accept_valid", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_valid", res_valid, 0);
        chk("t3_idle_data", res_data, 0);
        chk("t3_idle_grant", req_ready, 2'b01);
        req_valid = 2'b00;
        $display("t3 req1 0*63 held then accepted");

        // Test 4: reset during MUL step 2, then rerun
        do_reset();
        req_valid = 2'b01; req_a0 = 4'd9; req_b0 = 6'd22; res_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        chk("t4_step1_m", mul_m, 2);
        chk("t4_step1_q", mul_q, 6);
        @(negedge clk); #1;
        chk("t4_step2_m", mul_m, 1);
        chk("t4_step2_q", mul_q, 2);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", res_valid, 0);
        chk("t4_rst_mul_m", mul_m, 0);
        chk("t4_rst_mul_q", mul_q, 0);
        chk("t4_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 chk("t4_no_result", res_valid, 0);
            @(negedge clk);
        end
        req_valid = 2'b01;
        #1 chk("t4_regrant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        chk("t4_res_valid", res_valid, 1);
        chk("t4_res_data", res_data, 198);
        chk("t4_res_id", res_id, 0);
        $display("t4 req0 9*22 after abort -> %0d", res_data);

        // Test 5: random regression with per-requester scoreboards
        do_reset();
        hs = 2'b00; nres = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        ra[0] = 4'd0; ra[1] = 4'd0; rb[0] = 6'd0; rb[1] = 6'd0;
        for (int cyc = 0; cyc < 30000 && nres < 1000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    ra[i] = 4'($urandom);
                    rb[i] = 6'($urandom);
                end
            end
            req_valid = {pend[1], pend[0]};
            req_a0 = ra[0]; req_b0 = rb[0]; req_a1 = ra[1]; req_b1 = rb[1];
            res_ready = ($urandom_range(3, 0) != 0);
            #1;
            chk("rand_no_grant_busy", busy && (req_ready != 2'b00), 0);
            hs = req_ready & req_valid;
            if (hs[0]) q0.push_back(int'(ra[0]) * int'(rb[0]));
            if (hs[1]) q1.push_back(int'(ra[1]) * int'(rb[1]));
            if (res_valid && res_ready) begin
                if (res_id == 1'b0) begin
                    chk("rand_q0_nonempty", q0.size() != 0, 1);
                    if (q0.size() != 0) begin
                        exp_v = q0.pop_front();
                        chk("rand_res0", res_data, exp_v);
                    end
                end else begin
                    chk("rand_q1_nonempty", q1.size() != 0, 1);
                    if (q1.size() != 0) begin
                        exp_v = q1.pop_front();
                        chk("rand_res1", res_data, exp_v);
                    end
                end
                nres++;
            end
            @(negedge clk);
        end
        chk("rand_result_count", nres, 1000);
        $display("random regression results %0d", nres);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
